emif_amm_mport_arb: RTL and testbench
=====================================

EMIF_AMM_MPORT_ARB -- requirements
Module: emif_amm_mport_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NPORTS, 4, number of Avalon-MM slave ports (2..8)
- DATA_W, 128, data width
- ADDR_W, 27, word address width
- BURST_W, 7, burstcount width
- TAG_DEPTH, 16, outstanding read bursts (power of 2)

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset (name, direction, width, meaning):
- emif_usr_clk, in, 1, sole clock
- emif_usr_reset_n, in, 1, async active-low reset

REQ-003 The per-port signals SHALL be flattened, with port p occupying slice p:
- s_read / s_write, in, NPORTS, requests
- s_address, in, NPORTS*ADDR_W, request address
- s_writedata, in, NPORTS*DATA_W, write data
- s_byteenable, in, NPORTS*DATA_W/8, byte enables
- s_burstcount, in, NPORTS*BURST_W, burst length
- s_ready, out, NPORTS, waitrequest_n
- s_readdata, out, DATA_W, broadcast read data
- s_readdatavalid, out, NPORTS, per-port read data valid

REQ-004 The EMIF side SHALL have:
- amm_ready, in, 1, controller ready
- amm_read / amm_write, out, 1, requests
- amm_address, out, ADDR_W, address
- amm_writedata, out, DATA_W, write data
- amm_byteenable, out, DATA_W/8, byte enables
- amm_burstcount, out, BURST_W, burst length
- amm_readdata, in, DATA_W, read data
- amm_readdatavalid, in, 1, read data valid
- err_orphan, out, 1, sticky error flag

Function
REQ-005 A port SHALL request when s_read[p] or s_write[p] is high; if both are high, it SHALL be treated as a write and the read ignored.
REQ-006 When unlocked, grant SHALL be combinational round-robin: the lowest index at or above rr_ptr that requests, wrapping modulo NPORTS.
REQ-007 amm_* command outputs SHALL mirror the granted port, with zero added latency.
REQ-008 s_ready[g] SHALL equal amm_ready for the granted port g; all other s_ready SHALL be 0.
REQ-009 A beat SHALL be accepted when amm_ready is high and amm_read or amm_write is high.
REQ-010 On the first write beat with burstcount B>1, the block SHALL lock the grant to that port, load beat_cnt=B-1 and decrement it per accepted beat; it SHALL unlock when beat_cnt reaches 0.
REQ-011 A read SHALL be a single command beat; on acceptance, {port, burstcount} SHALL be pushed into the tag FIFO.
REQ-012 rr_ptr SHALL advance to g+1 (mod NPORTS) when a read is accepted or the final write beat is accepted.
REQ-013 While the tag FIFO is full, read requests SHALL be masked from arbitration; writes SHALL remain eligible.
REQ-014 s_readdata SHALL equal amm_readdata; s_readdatavalid[head.port] SHALL equal amm_readdatavalid.
REQ-015 The head remaining count SHALL decrement per valid beat, and the head SHALL pop on its last beat; a push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-016 amm_readdatavalid with the tag FIFO empty SHALL set err_orphan (cleared only by reset) and drive no s_readdatavalid.
REQ-017 burstcount 0 SHALL be treated as 1.

Reset
REQ-018 While emif_usr_reset_n is low, the following SHALL be cleared: rr_ptr=0, lock=0, beat_cnt=0, tag FIFO empty, err_orphan=0.
REQ-019 Reset outputs SHALL be: amm_read=amm_write=0, s_ready=0, s_readdatavalid=0.
REQ-020 Reset asserted mid-burst or with reads outstanding SHALL discard all state; no response SHALL be routed afterwards.

Configuration
REQ-021 With EMIF_ARB_PERF_EN defined, the block SHALL add input perf_clr (1) and output perf_grant_cnt (NPORTS*32): per-port saturating counts of accepted commands (a burst counts once), cleared by reset or perf_clr (clear wins over increment).
REQ-022 Without EMIF_ARB_PERF_EN, those ports and counters SHALL be absent.

Verification
REQ-023 Ports 0..3 read continuously with amm_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-024 Port 1 writes B=4 while port 2 requests -> 4 beats from port 1 uninterrupted, then port 2 granted; amm_ready low mid-burst holds the lock.
REQ-025 Port 0 reads B=2 then port 3 reads B=3; 5 valid beats returned -> s_readdatavalid[0] for 2 beats, then [3] for 3 beats.
REQ-026 16 reads outstanding with no data -> further reads get s_ready=0 while a write is still granted; one beat returned with B=1 head -> read granted the next cycle.
REQ-027 amm_readdatavalid with no outstanding reads -> err_orphan=1 and stays 1; reset mid-write-burst -> amm_write=0 and rr_ptr=0.
REQ-028 With EMIF_ARB_PERF_EN: 10 reads from port 2 -> perf_grant_cnt[2]=10; perf_clr -> 0.

Source files
------------

// File: rtl/emif_amm_mport_arb.sv
// Multi-port Avalon-MM arbiter in front of an EMIF controller: round-robin grant,
// write-burst locking, read-tag FIFO for response routing. Optional perf counters via EMIF_ARB_PERF_EN.
module emif_amm_mport_arb #(
    parameter int NPORTS    = 4,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 27,
    parameter int BURST_W   = 7,
    parameter int TAG_DEPTH = 16
) (
    input  logic                        emif_usr_clk,
    input  logic                        emif_usr_reset_n,
    input  logic [NPORTS-1:0]           s_read,
    input  logic [NPORTS-1:0]           s_write,
    input  logic [NPORTS*ADDR_W-1:0]    s_address,
    input  logic [NPORTS*DATA_W-1:0]    s_writedata,
    input  logic [NPORTS*DATA_W/8-1:0]  s_byteenable,
    input  logic [NPORTS*BURST_W-1:0]   s_burstcount,
    output logic [NPORTS-1:0]           s_ready,
    output logic [DATA_W-1:0]           s_readdata,
    output logic [NPORTS-1:0]           s_readdatavalid,
    input  logic                        amm_ready,
    output logic                        amm_read,
    output logic                        amm_write,
    output logic [ADDR_W-1:0]           amm_address,
    output logic [DATA_W-1:0]           amm_writedata,
    output logic [DATA_W/8-1:0]         amm_byteenable,
    output logic [BURST_W-1:0]          amm_burstcount,
    input  logic [DATA_W-1:0]           amm_readdata,
    input  logic                        amm_readdatavalid,
`ifdef EMIF_ARB_PERF_EN
    input  logic                        perf_clr,
    output logic [NPORTS*32-1:0]        perf_grant_cnt,
`endif
    output logic                        err_orphan
);

    localparam int PW   = $clog2(NPORTS);
    localparam int TW   = $clog2(TAG_DEPTH);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_t;

    arb_state_t state, next_state;

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      lock_port;
    logic [BURST_W-1:0] beat_cnt;

    logic [PW-1:0]      tag_port [TAG_DEPTH];
    logic [BURST_W-1:0] tag_cnt  [TAG_DEPTH];
    logic [TW-1:0]      rd_ptr;
    logic [TW-1:0]      wr_ptr;
    logic [TW:0]        tag_count;

    logic               tag_full;
    logic               tag_empty;
    logic [NPORTS-1:0]  eligible;
    logic [PW-1:0]      cand;
    logic [PW-1:0]      grant;
    logic               grant_vld;
    logic [BURST_W-1:0] g_bc_raw;
    logic [BURST_W-1:0] g_bc;
    logic               write_accept;
    logic               read_accept;
    logic               first_beat;
    logic               last_write;
    logic [PW-1:0]      head_port;
    logic [BURST_W-1:0] head_cnt;
    logic               rvalid_route;
    logic               push;
    logic               pop;

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            state <= ARB_OPEN;
        end else begin
            state <= next_state;
        end
    end

    // Grant selection, command mux and burst-lock transitions; reads are hidden while the tag FIFO is full
    always_comb begin
        tag_full     = (tag_count == (TW+1)'(TAG_DEPTH));
        tag_empty    = (tag_count == '0);
        eligible     = s_write | (s_read & {NPORTS{~tag_full}});
        next_state   = state;
        grant        = '0;
        grant_vld    = 1'b0;
        cand         = '0;

        if (state == ARB_LOCKED) begin
            grant     = lock_port;
            grant_vld = s_write[lock_port];
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                cand = PW'((int'(rr_ptr) + i) % NPORTS);
                if (!grant_vld && eligible[cand]) begin
                    grant     = cand;
                    grant_vld = 1'b1;
                end
            end
        end

        if (!emif_usr_reset_n) begin
            grant_vld = 1'b0;
        end

        g_bc_raw = s_burstcount[int'(grant)*BURST_W +: BURST_W];
        g_bc     = (g_bc_raw == '0) ? BURST_W'(1) : g_bc_raw;

        amm_write      = grant_vld & s_write[grant];
        amm_read       = grant_vld & ~s_write[grant];
        amm_address    = s_address[int'(grant)*ADDR_W +: ADDR_W];
        amm_writedata  = s_writedata[int'(grant)*DATA_W +: DATA_W];
        amm_byteenable = s_byteenable[int'(grant)*BE_W +: BE_W];
        amm_burstcount = g_bc;

        s_ready        = '0;
        s_ready[grant] = grant_vld & amm_ready;

        write_accept = amm_ready & amm_write;
        read_accept  = amm_ready & amm_read;
        first_beat   = write_accept & (state == ARB_OPEN);
        last_write   = write_accept &
                       ((state == ARB_OPEN) ? (g_bc == BURST_W'(1)) : (beat_cnt == BURST_W'(1)));

        if (first_beat && g_bc != BURST_W'(1)) begin
            next_state = ARB_LOCKED;
        end else if (state == ARB_LOCKED && last_write) begin
            next_state = ARB_OPEN;
        end
    end

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            rr_ptr    <= '0;
            lock_port <= '0;
            beat_cnt  <= '0;
        end else begin
            if (read_accept || last_write) begin
                rr_ptr <= (grant == PW'(NPORTS-1)) ? '0 : grant + PW'(1);
            end
            if (first_beat && g_bc != BURST_W'(1)) begin
                lock_port <= grant;
                beat_cnt  <= g_bc - BURST_W'(1);
            end else if (state == ARB_LOCKED && write_accept) begin
                beat_cnt  <= beat_cnt - BURST_W'(1);
            end
        end
    end

    // Read responses return in order, so the FIFO head always owns the current beat
    always_comb begin
        head_port    = tag_port[rd_ptr];
        head_cnt     = tag_cnt[rd_ptr];
        rvalid_route = amm_readdatavalid & ~tag_empty;
        push         = read_accept;
        pop          = rvalid_route & (head_cnt == BURST_W'(1));

        s_readdata                 = amm_readdata;
        s_readdatavalid            = '0;
        s_readdatavalid[head_port] = rvalid_route;
    end

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            tag_count  <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + TW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + TW'(1);
            end
            case ({push, pop})
                2'b10:   tag_count <= tag_count + (TW+1)'(1);
                2'b01:   tag_count <= tag_count - (TW+1)'(1);
                default: tag_count <= tag_count;
            endcase
            if (amm_readdatavalid && tag_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Push never lands on the head slot: that would need a full FIFO, where reads are masked
    always_ff @(posedge emif_usr_clk) begin
        if (push) begin
            tag_port[wr_ptr] <= grant;
            tag_cnt[wr_ptr]  <= g_bc;
        end
        if (rvalid_route && !pop) begin
            tag_cnt[rd_ptr] <= head_cnt - BURST_W'(1);
        end
    end

`ifdef EMIF_ARB_PERF_EN
    logic        cmd_accept;
    logic [31:0] perf_cnt [NPORTS];

    assign cmd_accept = read_accept | first_beat;

    // A write burst is counted once, on its first beat
    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            for (int p = 0; p < NPORTS; p++) begin
                perf_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (perf_clr) begin
                    perf_cnt[p] <= '0;
                end else if (cmd_accept && grant == PW'(p) && perf_cnt[p] != 32'hFFFF_FFFF) begin
                    perf_cnt[p] <= perf_cnt[p] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int p = 0; p < NPORTS; p++) begin
            perf_grant_cnt[p*32 +: 32] = perf_cnt[p];
        end
    end
`endif

endmodule

// File: tb/tb_emif_amm_mport_arb.sv
// Randomized and directed bench for emif_amm_mport_arb against a queue-based behavioural model.
module tb_emif_amm_mport_arb;

    localparam int NPORTS    = 4;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int BURST_W   = 7;
    localparam int TAG_DEPTH = 16;
    localparam int BE_W      = DATA_W / 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NPORTS-1:0]          s_read;
    logic [NPORTS-1:0]          s_write;
    logic [NPORTS*ADDR_W-1:0]   s_address;
    logic [NPORTS*DATA_W-1:0]   s_writedata;
    logic [NPORTS*BE_W-1:0]     s_byteenable;
    logic [NPORTS*BURST_W-1:0]  s_burstcount;
    logic [NPORTS-1:0]          s_ready;
    logic [DATA_W-1:0]          s_readdata;
    logic [NPORTS-1:0]          s_readdatavalid;
    logic                       amm_ready;
    logic                       amm_read;
    logic                       amm_write;
    logic [ADDR_W-1:0]          amm_address;
    logic [DATA_W-1:0]          amm_writedata;
    logic [BE_W-1:0]            amm_byteenable;
    logic [BURST_W-1:0]         amm_burstcount;
    logic [DATA_W-1:0]          amm_readdata;
    logic                       amm_readdatavalid;
    logic                       err_orphan;
`ifdef EMIF_ARB_PERF_EN
    logic                       perf_clr = 1'b0;
    logic [NPORTS*32-1:0]       perf_grant_cnt;
`endif

    always #5 clk = ~clk;

    emif_amm_mport_arb #(
        .NPORTS(NPORTS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .emif_usr_clk(clk),
        .emif_usr_reset_n(rst_n),
        .s_read(s_read),
        .s_write(s_write),
        .s_address(s_address),
        .s_writedata(s_writedata),
        .s_byteenable(s_byteenable),
        .s_burstcount(s_burstcount),
        .s_ready(s_ready),
        .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .amm_ready(amm_ready),
        .amm_read(amm_read),
        .amm_write(amm_write),
        .amm_address(amm_address),
        .amm_writedata(amm_writedata),
        .amm_byteenable(amm_byteenable),
        .amm_burstcount(amm_burstcount),
        .amm_readdata(amm_readdata),
        .amm_readdatavalid(amm_readdatavalid),
`ifdef EMIF_ARB_PERF_EN
        .perf_clr(perf_clr),
        .perf_grant_cnt(perf_grant_cnt),
`endif
        .err_orphan(err_orphan)
    );

    // Outstanding read bursts in issue order, each with the beats still owed
    typedef struct {
        int port;
        int left;
    } tag_t;

    tag_t              tag_q[$];
    int                m_rr;
    int                m_lock;
    int                m_left;
    bit                m_err;
    int                m_perf [NPORTS];
    int                n_checks;
    int                n_errors;
    logic [NPORTS-1:0] rnd_rd;
    logic [NPORTS-1:0] rnd_wr;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [NPORTS-1:0] rd, input logic [NPORTS-1:0] wr,
                                  input int bc, input bit rdy, input bit rdv);
        s_read  = rd;
        s_write = wr;
        for (int p = 0; p < NPORTS; p++) begin
            s_address[p*ADDR_W +: ADDR_W]     = ADDR_W'($urandom);
            s_writedata[p*DATA_W +: DATA_W]   = DATA_W'($urandom);
            s_byteenable[p*BE_W +: BE_W]      = BE_W'($urandom);
            s_burstcount[p*BURST_W +: BURST_W] = BURST_W'(bc);
        end
        amm_ready         = rdy;
        amm_readdatavalid = rdv;
        amm_readdata      = DATA_W'($urandom);
    endtask

    task automatic model_reset();
        tag_q.delete();
        m_rr   = 0;
        m_lock = -1;
        m_left = 0;
        m_err  = 1'b0;
        for (int p = 0; p < NPORTS; p++) m_perf[p] = 0;
    endtask

    // Sample at the falling edge, compare against the model, then advance the model by one cycle
    task automatic run_cycle();
        int                g;
        int                bc;
        bit                gv;
        bit                full;
        logic [NPORTS-1:0] exp_ready;
        logic [NPORTS-1:0] exp_rdv;
        tag_t              h;
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
            check_output("rst_amm_read", amm_read, 0);
            check_output("rst_amm_write", amm_write, 0);
            check_output("rst_s_ready", s_ready, 0);
            check_output("rst_s_readdatavalid", s_readdatavalid, 0);
            check_output("rst_err_orphan", err_orphan, 0);
        end else begin
            full = (tag_q.size() >= TAG_DEPTH);
            gv   = 1'b0;
            g    = 0;
            if (m_lock >= 0) begin
                g  = m_lock;
                gv = s_write[g];
            end else begin
                for (int k = 0; k < NPORTS; k++) begin
                    int p;
                    p = (m_rr + k) % NPORTS;
                    if (!gv && (s_write[p] || (s_read[p] && !full))) begin
                        g  = p;
                        gv = 1'b1;
                    end
                end
            end
            bc = int'(s_burstcount[g*BURST_W +: BURST_W]);
            if (bc == 0) bc = 1;

            check_output("amm_write", amm_write, gv && s_write[g]);
            check_output("amm_read", amm_read, gv && !s_write[g]);
            exp_ready = (gv && amm_ready) ? (NPORTS'(1) << g) : '0;
            check_output("s_ready", s_ready, exp_ready);
            if (gv) begin
                check_output("amm_address", amm_address, s_address[g*ADDR_W +: ADDR_W]);
                check_output("amm_burstcount", amm_burstcount, bc);
                if (s_write[g]) begin
                    check_output("amm_writedata", amm_writedata, s_writedata[g*DATA_W +: DATA_W]);
                    check_output("amm_byteenable", amm_byteenable, s_byteenable[g*BE_W +: BE_W]);
                end
            end
            exp_rdv = '0;
            if (amm_readdatavalid && tag_q.size() > 0) exp_rdv[tag_q[0].port] = 1'b1;
            check_output("s_readdatavalid", s_readdatavalid, exp_rdv);
            check_output("s_readdata", s_readdata, amm_readdata);
            check_output("err_orphan", err_orphan, m_err);
`ifdef EMIF_ARB_PERF_EN
            for (int p = 0; p < NPORTS; p++) begin
                check_output($sformatf("perf_grant_cnt[%0d]", p), perf_grant_cnt[p*32 +: 32], m_perf[p]);
            end
`endif
            if (amm_readdatavalid) begin
                if (tag_q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    h = tag_q[0];
                    h.left--;
                    if (h.left == 0) tag_q.delete(0);
                    else tag_q[0] = h;
                end
            end
            if (gv && amm_ready) begin
                if (s_write[g]) begin
                    if (m_lock < 0) begin
                        m_perf[g]++;
                        if (bc > 1) begin
                            m_lock = g;
                            m_left = bc - 1;
                        end else begin
                            m_rr = (g + 1) % NPORTS;
                        end
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_lock = -1;
                            m_rr   = (g + 1) % NPORTS;
                        end
                    end
                end else begin
                    h.port = g;
                    h.left = bc;
                    tag_q.push_back(h);
                    m_perf[g]++;
                    m_rr = (g + 1) % NPORTS;
                end
            end
`ifdef EMIF_ARB_PERF_EN
            if (perf_clr) begin
                for (int p = 0; p < NPORTS; p++) m_perf[p] = 0;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_reads();
        for (int i = 0; i < 300 && tag_q.size() > 0; i++) begin
            apply_stimulus('0, '0, 1, 1'b1, 1'b1);
            run_cycle();
        end
        check_output("drain_empty", tag_q.size(), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        apply_stimulus(4'b1111, 4'b0000, 1, 1'b1, 1'b0);
        repeat (2) run_cycle();
        rst_n = 1'b1;

        // All ports reading continuously: grants rotate 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(4'b1111, 4'b0000, 1, 1'b1, 1'b0);
            run_cycle();
        end
        drain_reads();

        // Port 1 write burst of 4 with port 2 waiting; a stall in the middle keeps the lock
        apply_stimulus(4'b0100, 4'b0010, 4, 1'b1, 1'b0); run_cycle();
        apply_stimulus(4'b0100, 4'b0010, 4, 1'b1, 1'b0); run_cycle();
        apply_stimulus(4'b0100, 4'b0010, 4, 1'b0, 1'b0); run_cycle();
        apply_stimulus(4'b0100, 4'b0010, 4, 1'b1, 1'b0); run_cycle();
        apply_stimulus(4'b0100, 4'b0010, 4, 1'b1, 1'b0); run_cycle();
        apply_stimulus(4'b0100, 4'b0000, 1, 1'b1, 1'b0); run_cycle();
        drain_reads();

        // Port 0 reads two beats, port 3 reads three, responses routed in order
        apply_stimulus(4'b0001, 4'b0000, 2, 1'b1, 1'b0); run_cycle();
        apply_stimulus(4'b1000, 4'b0000, 3, 1'b1, 1'b0); run_cycle();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus('0, '0, 1, 1'b1, 1'b1);
            run_cycle();
        end

        // Fill the tag FIFO, then check read masking and recovery after one returned beat
        for (int i = 0; i < TAG_DEPTH; i++) begin
            apply_stimulus(4'b0001, 4'b0000, 1, 1'b1, 1'b0);
            run_cycle();
        end
        apply_stimulus(4'b0001, 4'b0010, 1, 1'b1, 1'b0); run_cycle();
        apply_stimulus(4'b0001, 4'b0000, 1, 1'b1, 1'b1); run_cycle();
        apply_stimulus(4'b0001, 4'b0000, 1, 1'b1, 1'b0); run_cycle();
        drain_reads();

        // Random traffic with burst lengths including zero
        for (int cyc = 0; cyc < 400; cyc++) begin
            rnd_rd = NPORTS'($urandom);
            rnd_wr = NPORTS'($urandom) & NPORTS'($urandom);
            apply_stimulus(rnd_rd, rnd_wr, 1, $urandom_range(0, 3) != 0,
                           (tag_q.size() > 0) && ($urandom_range(0, 1) == 1));
            for (int p = 0; p < NPORTS; p++) begin
                s_burstcount[p*BURST_W +: BURST_W] = BURST_W'($urandom_range(0, 5));
            end
            run_cycle();
        end
        drain_reads();

        // Orphan read data sets a sticky error
        apply_stimulus('0, '0, 1, 1'b1, 1'b1); run_cycle();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'b0001, 4'b0000, 1, 1'b0, 1'b0);
            run_cycle();
        end

        // Reset in the middle of a write burst, then all ports write: port 0 wins
        apply_stimulus('0, 4'b0100, 4, 1'b1, 1'b0); run_cycle();
        apply_stimulus('0, 4'b0100, 4, 1'b1, 1'b0); run_cycle();
        rst_n = 1'b0;
        apply_stimulus('0, 4'b1111, 1, 1'b1, 1'b0); run_cycle();
        rst_n = 1'b1;
        apply_stimulus('0, 4'b1111, 1, 1'b1, 1'b0); run_cycle();
        apply_stimulus('0, 4'b0000, 1, 1'b1, 1'b0); run_cycle();

`ifdef EMIF_ARB_PERF_EN
        // Ten reads from port 2, then a clear
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(4'b0100, 4'b0000, 1, 1'b1, 1'b1);
            run_cycle();
        end
        drain_reads();
        check_output("perf_model_port2", m_perf[2], 10);
        apply_stimulus('0, '0, 1, 1'b1, 1'b0);
        run_cycle();
        perf_clr = 1'b1;
        apply_stimulus(4'b0100, '0, 1, 1'b1, 1'b0);
        run_cycle();
        perf_clr = 1'b0;
        apply_stimulus('0, '0, 1, 1'b1, 1'b1);
        run_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
